// File: rtl/systolic_array_ws_pkg.sv
// Shared types and helpers for the weight-stationary systolic matrix-vector engine.
//   state_t : controller states (IDLE, LOAD, RUN, DRAIN)
//   psw_of  : partial-sum/result width for a given operand width and array size
package systolic_array_ws_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Wide enough for N full-scale products without overflow.
    function automatic int unsigned psw_of(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_array_ws_if.sv
// Bus bundle between the operand buffer / result collector and the systolic engine.
//   w_valid/w_ready/w_data    : weight rows, slice j = W[row][j]
//   in_valid/in_ready/in_data : input vectors, slice i = x[i]
//   out_valid/out_data        : result strobe, slice j = y[j], no backpressure
// master = traffic source/sink side, slave = engine side.
interface systolic_array_ws_if
    import systolic_array_ws_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned DW  = 8,
    parameter int unsigned PSW = psw_of(DW, N)
);
    logic              w_valid;
    logic              w_ready;
    logic [N*DW-1:0]   w_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic [N*PSW-1:0]  out_data;

    modport master (
        output w_valid, w_data, in_valid, in_data,
        input  w_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  w_valid, w_data, in_valid, in_data,
        output w_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/systolic_array_ws_pe.sv
// One processing element: holds a stationary weight, forwards x to the right and
// adds x*w into the partial sum flowing downward. Both outputs are registered.
//   clk, clear        : clock, synchronous active-high clear
//   w_we, w_in        : weight write enable (row select) and weight value
//   x_in, x_out       : operand in from the left, registered copy to the right
//   psum_in, psum_out : partial sum from above, registered sum to below
module systolic_array_ws_pe
    import systolic_array_ws_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned PSW    = 18,
    parameter bit          SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           w_we,
    input  logic [DW-1:0]  w_in,
    input  logic [DW-1:0]  x_in,
    input  logic [PSW-1:0] psum_in,
    output logic [DW-1:0]  x_out,
    output logic [PSW-1:0] psum_out
);
    localparam int unsigned EXT = PSW - DW;

    logic [DW-1:0]  w_q;
    logic [PSW-1:0] x_ext;
    logic [PSW-1:0] w_ext;

    // Extend operands to the full sum width; the truncated product is exact mod 2^PSW.
    if (SIGNED) begin : g_sext
        assign x_ext = {{EXT{x_in[DW-1]}}, x_in};
        assign w_ext = {{EXT{w_q[DW-1]}}, w_q};
    end else begin : g_zext
        assign x_ext = {{EXT{1'b0}}, x_in};
        assign w_ext = {{EXT{1'b0}}, w_q};
    end

    // Weight register, x pass-through and MAC.
    always_ff @(posedge clk) begin
        if (clear) begin
            w_q      <= '0;
            x_out    <= '0;
            psum_out <= '0;
        end else begin
            if (w_we) begin
                w_q <= w_in;
            end
            x_out    <= x_in;
            psum_out <= psum_in + x_ext * w_ext;
        end
    end
endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary NxN systolic matrix-vector engine: y[j] = sum_i x[i]*W[i][j].
// Weights are loaded row by row, inputs stream one vector per cycle, results
// come out 2N-1 cycles after acceptance in input order.
//   clk   : clock, rising edge
//   clear : synchronous active-high clear of FSM, weights and all pipelines
//   bus   : weight / input handshakes and result strobe (slave side)
module systolic_array_ws
    import systolic_array_ws_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DW     = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                clear,
    systolic_array_ws_if.slave  bus
);
    localparam int unsigned PSW = psw_of(DW, N);
    localparam int unsigned RW  = $clog2(N);
    localparam int unsigned VL  = 2 * N - 1;

    state_t          state;
    logic [RW-1:0]   row;
    logic            w_ready_q;
    logic            in_ready_q;
    logic [VL-1:0]   vpipe;
    logic            w_acc;
    logic            in_acc;
    logic            drain_done;

    logic [DW-1:0]   x_h  [N][N+1];
    logic [PSW-1:0]  ps_v [N+1][N];
    logic [PSW-1:0]  col  [N];

    assign w_acc  = bus.w_valid  & w_ready_q;
    assign in_acc = bus.in_valid & in_ready_q;

    // Only the final stage may still hold a beat; it strobes this cycle.
    assign drain_done = (vpipe[VL-2:0] == '0);

    // Controller with registered handshake outputs; valid pipeline tracks in-flight beats.
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= ST_IDLE;
            row        <= '0;
            w_ready_q  <= 1'b1;
            in_ready_q <= 1'b0;
            vpipe      <= '0;
        end else begin
            vpipe <= {vpipe[VL-2:0], in_acc};
            case (state)
                ST_IDLE: begin
                    if (w_acc) begin
                        state <= ST_LOAD;
                        row   <= RW'(1);
                    end
                end
                ST_LOAD: begin
                    if (w_acc) begin
                        if (row == RW'(N - 1)) begin
                            state      <= ST_RUN;
                            row        <= '0;
                            w_ready_q  <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.w_valid) begin
                        state      <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state     <= ST_LOAD;
                        row       <= '0;
                        w_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    row        <= '0;
                    w_ready_q  <= 1'b1;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Input skew: row i sees x[i] i cycles late; non-accepted cycles inject zeros.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] x_new;
        assign x_new = in_acc ? bus.in_data[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign x_h[i][0] = x_new;
        end else begin : g_sr
            logic [DW-1:0] sr [i];
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int k = 0; k < i; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= x_new;
                    for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
                end
            end
            assign x_h[i][0] = sr[i-1];
        end
    end

    // PE grid: x flows right, partial sums flow down from a zero top row.
    for (genvar j = 0; j < N; j++) begin : g_top
        assign ps_v[0][j] = '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_array_ws_pe #(
                .DW     (DW),
                .PSW    (PSW),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk      (clk),
                .clear    (clear),
                .w_we     (w_acc && (row == RW'(i))),
                .w_in     (bus.w_data[j*DW +: DW]),
                .x_in     (x_h[i][j]),
                .psum_in  (ps_v[i][j]),
                .x_out    (x_h[i][j+1]),
                .psum_out (ps_v[i+1][j])
            );
        end
    end

    // Output deskew: column j waits N-1-j cycles so all columns line up.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        localparam int unsigned D = N - 1 - j;
        if (D == 0) begin : g_direct
            assign col[j] = ps_v[N][j];
        end else begin : g_sr
            logic [PSW-1:0] sr [D];
            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= ps_v[N][j];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign col[j] = sr[D-1];
        end
        assign bus.out_data[j*PSW +: PSW] = vpipe[VL-1] ? col[j] : '0;
    end

    assign bus.out_valid = vpipe[VL-1];
    assign bus.w_ready   = w_ready_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws (N=4, DW=8). A signed and an unsigned
// instance share all inputs; results are matched against a queue of hand-computed
// expectations with a fixed 7-cycle latency.
module tb_systolic_array_ws;
    import systolic_array_ws_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned PSW = psw_of(DW, N);
    localparam int          LAT = 2 * N - 1;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    systolic_array_ws_if #(.N(N), .DW(DW), .PSW(PSW)) bus  ();
    systolic_array_ws_if #(.N(N), .DW(DW), .PSW(PSW)) ubus ();

    assign ubus.w_valid  = bus.w_valid;
    assign ubus.w_data   = bus.w_data;
    assign ubus.in_valid = bus.in_valid;
    assign ubus.in_data  = bus.in_data;

    systolic_array_ws #(.N(N), .DW(DW), .SIGNED(1'b1)) dut   (.clk(clk), .clear(clear), .bus(bus));
    systolic_array_ws #(.N(N), .DW(DW), .SIGNED(1'b0)) dut_u (.clk(clk), .clear(clear), .bus(ubus));

    typedef struct {
        logic [N*DW-1:0]         x;
        logic [N-1:0][PSW-1:0]   y;
        logic [PSW-1:0]          yu;
        int                      acc;
    } rec_t;

    rec_t expq[$];
    rec_t id_tab[3];
    rec_t st_tab[10];
    rec_t nil;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   strobes = 0;
    bit   chk_u   = 1'b0;

    function automatic rec_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3,
                                input int yu);
        rec_t r;
        r.x    = {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
        r.y[0] = PSW'(y0);
        r.y[1] = PSW'(y1);
        r.y[2] = PSW'(y2);
        r.y[3] = PSW'(y3);
        r.yu   = PSW'(yu);
        r.acc  = 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and check the result port against the scoreboard.
    task automatic step();
        rec_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid) begin
            strobes++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: out_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = expq.pop_front();
                chk("latency", 128'(cyc - e.acc), 128'(LAT));
                chk("y", 128'(bus.out_data), 128'(e.y));
                if (chk_u) begin
                    chk("out_valid_unsigned", 128'(ubus.out_valid), 128'(1));
                    for (int j = 0; j < N; j++)
                        chk("y_unsigned", 128'(ubus.out_data[j*PSW +: PSW]), 128'(e.yu));
                end
            end
        end else begin
            chk("out_data_idle", 128'(bus.out_data), 128'(0));
        end
    endtask

    task automatic drive(input bit iv, input rec_t r, input bit wv,
                         input logic [N*DW-1:0] wd, output bit w_acc);
        bus.in_valid = iv;
        bus.in_data  = r.x;
        bus.w_valid  = wv;
        bus.w_data   = wd;
        if (iv && bus.in_ready) begin
            r.acc = cyc;
            expq.push_back(r);
        end
        w_acc = wv && bus.w_ready;
        step();
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
    endtask

    task automatic idle();
        bit a;
        drive(1'b0, nil, 1'b0, '0, a);
    endtask

    task automatic load_row(input logic [N*DW-1:0] wd);
        bit a;
        a = 1'b0;
        for (int k = 0; k < 40 && !a; k++) drive(1'b0, nil, 1'b1, wd, a);
        chk("w_accept", 128'(a), 128'(1));
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 40 && expq.size() != 0; k++) idle();
        chk("results_done", 128'(expq.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int a2;
        int t;
        int s0;

        nil = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Identity weights: y = x.
        id_tab[0] = mk(1, 2, 3, 4,         1, 2, 3, 4,         0);
        id_tab[1] = mk(-1, -128, 127, 0,   -1, -128, 127, 0,   0);
        id_tab[2] = mk(5, 0, 0, 9,         5, 0, 0, 9,         0);
        // W[i][j] = i+1: every y[j] = x0 + 2x1 + 3x2 + 4x3.
        st_tab[0] = mk(1, 0, 0, 0,         1, 1, 1, 1,         0);
        st_tab[1] = mk(0, 1, 0, 0,         2, 2, 2, 2,         0);
        st_tab[2] = mk(0, 0, 1, 0,         3, 3, 3, 3,         0);
        st_tab[3] = mk(0, 0, 0, 1,         4, 4, 4, 4,         0);
        st_tab[4] = mk(1, 1, 1, 1,         10, 10, 10, 10,     0);
        st_tab[5] = mk(1, 2, 3, 4,         30, 30, 30, 30,     0);
        st_tab[6] = mk(-1, -1, -1, -1,     -10, -10, -10, -10, 0);
        st_tab[7] = mk(127, 127, 127, 127, 1270, 1270, 1270, 1270, 0);
        st_tab[8] = mk(-128, 0, 0, 127,    380, 380, 380, 380, 0);
        st_tab[9] = mk(10, 20, 30, 40,     300, 300, 300, 300, 0);

        // Reset with in_valid asserted; it must be ignored.
        clear        = 1'b1;
        bus.w_valid  = 1'b0;
        bus.w_data   = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        step();
        step();
        chk("reset_w_ready",   128'(bus.w_ready),   128'(1));
        chk("reset_in_ready",  128'(bus.in_ready),  128'(0));
        chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_out_data",  128'(bus.out_data),  128'(0));
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) idle();
        chk("idle_in_ready", 128'(bus.in_ready), 128'(0));

        // Identity load; RUN only after the 4th row.
        load_row(32'h0000_0001);
        load_row(32'h0000_0100);
        load_row(32'h0001_0000);
        chk("load3_in_ready", 128'(bus.in_ready), 128'(0));
        chk("load3_w_ready",  128'(bus.w_ready),  128'(1));
        load_row(32'h0100_0000);
        chk("load4_in_ready", 128'(bus.in_ready), 128'(1));
        chk("load4_w_ready",  128'(bus.w_ready),  128'(0));
        for (int k = 0; k < 3; k++) drive(1'b1, id_tab[k], 1'b0, '0, a);
        wait_empty();

        // Reload W[i][j] = i+1, then stream 8 beats, 2 bubbles, 2 beats.
        load_row(32'h0101_0101);
        load_row(32'h0202_0202);
        load_row(32'h0303_0303);
        load_row(32'h0404_0404);
        for (int k = 0; k < 8; k++) begin
            chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
            drive(1'b1, st_tab[k], 1'b0, '0, a);
        end
        idle();
        idle();
        for (int k = 8; k < 10; k++) begin
            chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
            drive(1'b1, st_tab[k], 1'b0, '0, a);
        end
        wait_empty();

        // Reload with 3 beats in flight; the last one coincides with w_valid.
        drive(1'b1, st_tab[0], 1'b0, '0, a);
        drive(1'b1, st_tab[1], 1'b0, '0, a);
        a2 = cyc;
        drive(1'b1, st_tab[2], 1'b1, 32'h8080_8080, a);
        chk("reload_in_ready_fall", 128'(bus.in_ready), 128'(0));
        chk("reload_w_ready_low",   128'(bus.w_ready),  128'(0));
        t = cyc;
        a = 1'b0;
        for (int k = 0; k < 30 && !a; k++) begin
            t = cyc;
            drive(1'b0, nil, 1'b1, 32'h8080_8080, a);
        end
        chk("reload_w_ready_cycle", 128'(t - a2), 128'(8));
        chk("reload_old_results",   128'(expq.size()), 128'(0));
        load_row(32'h8080_8080);
        load_row(32'h8080_8080);
        load_row(32'h8080_8080);

        // Extremes: 0x80 everywhere, then 0xFF everywhere.
        chk_u = 1'b1;
        drive(1'b1, mk(-128, -128, -128, -128, 65536, 65536, 65536, 65536, 65536), 1'b0, '0, a);
        wait_empty();
        for (int k = 0; k < 4; k++) load_row(32'hFFFF_FFFF);
        drive(1'b1, mk(-1, -1, -1, -1, 4, 4, 4, 4, 260100), 1'b0, '0, a);
        wait_empty();
        chk_u = 1'b0;

        // Clear with 5 beats in flight: nothing may strobe afterwards.
        for (int k = 0; k < 5; k++) drive(1'b1, st_tab[k], 1'b0, '0, a);
        expq.delete();
        s0    = strobes;
        clear = 1'b1;
        idle();
        clear = 1'b0;
        chk("clear_w_ready",  128'(bus.w_ready),  128'(1));
        chk("clear_in_ready", 128'(bus.in_ready), 128'(0));
        for (int k = 0; k < 12; k++) idle();
        chk("no_strobe_after_clear", 128'(strobes - s0), 128'(0));

        // After clear the row counter restarts: exactly 4 rows reach RUN.
        load_row(32'h0000_0001);
        chk("clear_load1_in_ready", 128'(bus.in_ready), 128'(0));
        load_row(32'h0000_0100);
        load_row(32'h0001_0000);
        load_row(32'h0100_0000);
        chk("clear_load4_in_ready", 128'(bus.in_ready), 128'(1));
        drive(1'b1, mk(7, -3, 0, 100, 7, -3, 0, 100, 0), 1'b0, '0, a);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
